// File: rtl/color_pipe_pkg.sv
// -----------------------------------------------------------------------------
// color_pipe_pkg
// Shared definitions for the colour/intensity correction pipeline:
//   - configuration register addresses (offsets 0..2, gains 3..5, 6..7 unused)
//   - default geometry, black-level offsets and gains
//   - width helper functions for the product, multiply and config bus
//   - the packed video timing bundle carried down the delay line
//   - the 2x2 ordered-dither rank lookup used when COLOR_DITHER_EN is defined
// -----------------------------------------------------------------------------
package color_pipe_pkg;

    // Configuration register map
    localparam logic [2:0] CFG_OFF_R  = 3'd0;
    localparam logic [2:0] CFG_OFF_G  = 3'd1;
    localparam logic [2:0] CFG_OFF_B  = 3'd2;
    localparam logic [2:0] CFG_GAIN_R = 3'd3;
    localparam logic [2:0] CFG_GAIN_G = 3'd4;
    localparam logic [2:0] CFG_GAIN_B = 3'd5;

    // Default geometry
    localparam int DEF_IN_W  = 4;
    localparam int DEF_I_W   = 4;
    localparam int DEF_G_W   = 8;
    localparam int DEF_SHIFT = 11;
    localparam int DEF_OUT_W = 4;

    // Default black levels and gains, matching the original palette math
    localparam int DEF_OFF_R  = 'h50;
    localparam int DEF_OFF_G  = 'h00;
    localparam int DEF_OFF_B  = 'h30;
    localparam int DEF_GAIN_R = 'h7D;
    localparam int DEF_GAIN_G = 'h72;
    localparam int DEF_GAIN_B = 'h7F;

    // Video timing bundle; blanks idle high, syncs idle low
    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hs;
        logic vs;
    } timing_t;

    localparam timing_t TIMING_RESET = '{hblank: 1'b1, vblank: 1'b1, hs: 1'b0, vs: 1'b0};

    // Width of the colour * intensity product
    function automatic int p_width(input int in_w, input int i_w);
        return in_w + i_w;
    endfunction

    // Width of the (product - offset) * gain result
    function automatic int m_width(input int p_w, input int g_w);
        return p_w + g_w;
    endfunction

    // Config data bus is wide enough for either an offset or a gain
    function automatic int cfg_width(input int p_w, input int g_w);
        return (p_w > g_w) ? p_w : g_w;
    endfunction

    // 2x2 Bayer rank indexed by {line_odd, pix_odd}
    function automatic logic [1:0] dither_rank(input logic [1:0] idx);
        logic [1:0] rank;
        case (idx)
            2'd0:    rank = 2'd0;
            2'd1:    rank = 2'd2;
            2'd2:    rank = 2'd3;
            default: rank = 2'd1;
        endcase
        return rank;
    endfunction

endpackage

// File: rtl/color_channel_stage.sv
// -----------------------------------------------------------------------------
// color_channel_stage
// Three-stage datapath for one colour channel, advanced only when ce_pix=1:
//   S1: prod = colour * intensity
//   S2: diff = prod - offset, clamped at zero
//   S3: out  = saturate((diff * gain [+ dither]) >> SHIFT)
// Offset and gain are captured with the pixel at S1 and carried alongside it
// so a mid-stream commit never mixes old and new settings within one pixel.
// Optional: COLOR_DITHER_EN adds a per-pixel dither rank input (rank_i) that
// travels with the pixel and is added before the final shift.
//
// Ports:
//   clk_sys  in   pixel clock
//   reset    in   asynchronous active-high reset
//   ce_pix   in   pipeline advance enable
//   c_i      in   raw colour channel
//   i_i      in   intensity
//   off_i    in   active black-level offset
//   gain_i   in   active gain
//   rank_i   in   dither rank (only with COLOR_DITHER_EN)
//   c_o      out  corrected, saturated channel value
// -----------------------------------------------------------------------------
module color_channel_stage
    import color_pipe_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int I_W   = DEF_I_W,
    parameter int G_W   = DEF_G_W,
    parameter int SHIFT = DEF_SHIFT,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                              clk_sys,
    input  logic                              reset,
    input  logic                              ce_pix,
    input  logic [IN_W-1:0]                   c_i,
    input  logic [I_W-1:0]                    i_i,
    input  logic [p_width(IN_W, I_W)-1:0]     off_i,
    input  logic [G_W-1:0]                    gain_i,
`ifdef COLOR_DITHER_EN
    input  logic [1:0]                        rank_i,
`endif
    output logic [OUT_W-1:0]                  c_o
);

    localparam int P_W = p_width(IN_W, I_W);
    localparam int M_W = m_width(P_W, G_W);
    // One extra bit so the dither add can never wrap the multiply result
    localparam int S_W = M_W + 1;
    localparam logic [S_W-1:0] OUT_MAX = {{(S_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic [P_W-1:0]   prod_q, prod_d;
    logic [P_W-1:0]   offS1_q;
    logic [G_W-1:0]   gainS1_q;
    logic [P_W-1:0]   diff_q, diff_d;
    logic [G_W-1:0]   gainS2_q;
    logic [OUT_W-1:0] out_q, out_d;
    logic [M_W-1:0]   mult;
    logic [S_W-1:0]   sum;
    logic [S_W-1:0]   shifted;

`ifdef COLOR_DITHER_EN
    logic [1:0] rankS1_q;
    logic [1:0] rankS2_q;
`endif

    // Stage arithmetic: product, clamped subtraction, gain/shift/saturate
    always_comb begin
        prod_d  = P_W'(c_i) * P_W'(i_i);
        diff_d  = (prod_q > offS1_q) ? (prod_q - offS1_q) : '0;
        mult    = M_W'(diff_q) * M_W'(gainS2_q);
`ifdef COLOR_DITHER_EN
        sum     = S_W'(mult) + (S_W'(rankS2_q) << (SHIFT - 2));
`else
        sum     = S_W'(mult);
`endif
        shifted = sum >> SHIFT;
        out_d   = (shifted > OUT_MAX) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    end

    // Stage registers; offset/gain ride along with the pixel they belong to
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            prod_q   <= '0;
            offS1_q  <= '0;
            gainS1_q <= '0;
            diff_q   <= '0;
            gainS2_q <= '0;
            out_q    <= '0;
        end else if (ce_pix) begin
            prod_q   <= prod_d;
            offS1_q  <= off_i;
            gainS1_q <= gain_i;
            diff_q   <= diff_d;
            gainS2_q <= gainS1_q;
            out_q    <= out_d;
        end
    end

`ifdef COLOR_DITHER_EN
    // Dither rank follows the pixel down to the final stage
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rankS1_q <= '0;
            rankS2_q <= '0;
        end else if (ce_pix) begin
            rankS1_q <= rank_i;
            rankS2_q <= rankS1_q;
        end
    end
`endif

    assign c_o = out_q;

endmodule

// File: rtl/color_intensity_pipe.sv
// -----------------------------------------------------------------------------
// color_intensity_pipe
// Pipelined colour/intensity correction between the williams2 video outputs
// and arcade_video. Each channel computes
//   saturate(((c*i - off) clamped at 0) * gain >> SHIFT)
// with a fixed latency of three ce_pix cycles; blank/sync are delayed by the
// same amount and colour is forced to zero while the delayed blank is active.
// Offsets and gains are written into shadow registers at any time and copied
// to the active set together on the ce_pix cycle where vblank_in rises.
//
// Optional feature macro: COLOR_DITHER_EN (2x2 ordered dither before shift).
//
// Ports:
//   clk_sys                               in   pixel clock
//   reset                                 in   asynchronous active-high reset
//   ce_pix                                in   pipeline advance enable
//   r_in/g_in/b_in                        in   raw colour
//   i_in                                  in   intensity
//   hblank_in/vblank_in/hs_in/vs_in       in   video timing
//   cfg_we/cfg_addr/cfg_data              in   shadow register write port
//   cfg_pending                           out  shadow differs from active
//   r_out/g_out/b_out                     out  corrected colour
//   hblank_out/vblank_out/hs_out/vs_out   out  timing delayed three ce_pix cycles
// -----------------------------------------------------------------------------
module color_intensity_pipe
    import color_pipe_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int I_W    = DEF_I_W,
    parameter int G_W    = DEF_G_W,
    parameter int SHIFT  = DEF_SHIFT,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int OFF_R  = DEF_OFF_R,
    parameter int OFF_G  = DEF_OFF_G,
    parameter int OFF_B  = DEF_OFF_B,
    parameter int GAIN_R = DEF_GAIN_R,
    parameter int GAIN_G = DEF_GAIN_G,
    parameter int GAIN_B = DEF_GAIN_B
) (
    input  logic                                              clk_sys,
    input  logic                                              reset,
    input  logic                                              ce_pix,
    input  logic [IN_W-1:0]                                   r_in,
    input  logic [IN_W-1:0]                                   g_in,
    input  logic [IN_W-1:0]                                   b_in,
    input  logic [I_W-1:0]                                    i_in,
    input  logic                                              hblank_in,
    input  logic                                              vblank_in,
    input  logic                                              hs_in,
    input  logic                                              vs_in,
    input  logic                                              cfg_we,
    input  logic [2:0]                                        cfg_addr,
    input  logic [cfg_width(p_width(IN_W, I_W), G_W)-1:0]     cfg_data,
    output logic                                              cfg_pending,
    output logic [OUT_W-1:0]                                  r_out,
    output logic [OUT_W-1:0]                                  g_out,
    output logic [OUT_W-1:0]                                  b_out,
    output logic                                              hblank_out,
    output logic                                              vblank_out,
    output logic                                              hs_out,
    output logic                                              vs_out
);

    localparam int P_W = p_width(IN_W, I_W);

    logic [P_W-1:0]   offShadow_q  [3];
    logic [P_W-1:0]   offActive_q  [3];
    logic [G_W-1:0]   gainShadow_q [3];
    logic [G_W-1:0]   gainActive_q [3];
    logic             cfgPending_q, cfgPending_d;
    timing_t          tmg_q [3];
    timing_t          tmgIn;
    logic [2:0]       valid_q;
    logic             commit;
    logic             blankOut;
    logic [IN_W-1:0]  colIn  [3];
    logic [OUT_W-1:0] colOut [3];

    // tmg_q[0] holds vblank_in from the previous ce_pix edge, so this is a
    // ce-qualified rising edge; reset leaves it high so no spurious commit.
    assign commit = ce_pix & vblank_in & ~tmg_q[0].vblank;

    assign tmgIn = '{hblank: hblank_in, vblank: vblank_in, hs: hs_in, vs: vs_in};

    // Shadow writes and frame-start commit. Commit copies the shadow contents
    // as they were before this edge, so a coincident write stays pending.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            offShadow_q[0]  <= P_W'(OFF_R);
            offShadow_q[1]  <= P_W'(OFF_G);
            offShadow_q[2]  <= P_W'(OFF_B);
            gainShadow_q[0] <= G_W'(GAIN_R);
            gainShadow_q[1] <= G_W'(GAIN_G);
            gainShadow_q[2] <= G_W'(GAIN_B);
            offActive_q[0]  <= P_W'(OFF_R);
            offActive_q[1]  <= P_W'(OFF_G);
            offActive_q[2]  <= P_W'(OFF_B);
            gainActive_q[0] <= G_W'(GAIN_R);
            gainActive_q[1] <= G_W'(GAIN_G);
            gainActive_q[2] <= G_W'(GAIN_B);
        end else begin
            if (commit) begin
                offActive_q  <= offShadow_q;
                gainActive_q <= gainShadow_q;
            end
            if (cfg_we) begin
                case (cfg_addr)
                    CFG_OFF_R:  offShadow_q[0]  <= cfg_data[P_W-1:0];
                    CFG_OFF_G:  offShadow_q[1]  <= cfg_data[P_W-1:0];
                    CFG_OFF_B:  offShadow_q[2]  <= cfg_data[P_W-1:0];
                    CFG_GAIN_R: gainShadow_q[0] <= cfg_data[G_W-1:0];
                    CFG_GAIN_G: gainShadow_q[1] <= cfg_data[G_W-1:0];
                    CFG_GAIN_B: gainShadow_q[2] <= cfg_data[G_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Pending flag: cleared by a commit, otherwise reflects shadow != active
    always_comb begin
        cfgPending_d = 1'b0;
        if (!commit) begin
            for (int ch = 0; ch < 3; ch++) begin
                if ((offShadow_q[ch] != offActive_q[ch]) ||
                    (gainShadow_q[ch] != gainActive_q[ch])) begin
                    cfgPending_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cfgPending_q <= 1'b0;
        end else begin
            cfgPending_q <= cfgPending_d;
        end
    end

    // Timing delay line and valid tracking, matched to the colour latency
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tmg_q[0] <= TIMING_RESET;
            tmg_q[1] <= TIMING_RESET;
            tmg_q[2] <= TIMING_RESET;
            valid_q  <= '0;
        end else if (ce_pix) begin
            tmg_q[0] <= tmgIn;
            tmg_q[1] <= tmg_q[0];
            tmg_q[2] <= tmg_q[1];
            valid_q  <= {valid_q[1:0], 1'b1};
        end
    end

`ifdef COLOR_DITHER_EN
    logic       pixOdd_q;
    logic       lineOdd_q;
    logic [1:0] ditherRank;

    // Screen-position parity for the 2x2 dither grid. hs rising edge is found
    // against the previous ce-sampled hs held in the delay line.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pixOdd_q  <= 1'b0;
            lineOdd_q <= 1'b0;
        end else if (ce_pix) begin
            pixOdd_q <= hblank_in ? 1'b0 : ~pixOdd_q;
            if (vblank_in) begin
                lineOdd_q <= 1'b0;
            end else if (hs_in && !tmg_q[0].hs) begin
                lineOdd_q <= ~lineOdd_q;
            end
        end
    end

    assign ditherRank = dither_rank({lineOdd_q, pixOdd_q});
`endif

    assign colIn[0] = r_in;
    assign colIn[1] = g_in;
    assign colIn[2] = b_in;

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        color_channel_stage #(
            .IN_W  (IN_W),
            .I_W   (I_W),
            .G_W   (G_W),
            .SHIFT (SHIFT),
            .OUT_W (OUT_W)
        ) u_stage (
            .clk_sys (clk_sys),
            .reset   (reset),
            .ce_pix  (ce_pix),
            .c_i     (colIn[ch]),
            .i_i     (i_in),
            .off_i   (offActive_q[ch]),
            .gain_i  (gainActive_q[ch]),
`ifdef COLOR_DITHER_EN
            .rank_i  (ditherRank),
`endif
            .c_o     (colOut[ch])
        );
    end

    // Colour is suppressed while the aligned blank is active or the pipe is
    // still refilling after reset.
    assign blankOut = tmg_q[2].hblank | tmg_q[2].vblank | ~valid_q[2];

    assign r_out       = blankOut ? '0 : colOut[0];
    assign g_out       = blankOut ? '0 : colOut[1];
    assign b_out       = blankOut ? '0 : colOut[2];
    assign hblank_out  = tmg_q[2].hblank;
    assign vblank_out  = tmg_q[2].vblank;
    assign hs_out      = tmg_q[2].hs;
    assign vs_out      = tmg_q[2].vs;
    assign cfg_pending = cfgPending_q;

endmodule

// File: tb/tb_color_intensity_pipe.sv
// -----------------------------------------------------------------------------
// tb_color_intensity_pipe
// Directed bench for color_intensity_pipe in its default build: a table of
// pixels with hand-computed outputs streamed through the pipe, followed by
// sequences for config commit, timing alignment with ce gaps, write/commit
// collision, ignored addresses and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_color_intensity_pipe;
    import color_pipe_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic [3:0] r_in, g_in, b_in, i_in;
    logic       hblank_in, vblank_in, hs_in, vs_in;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_pending;
    logic [3:0] r_out, g_out, b_out;
    logic       hblank_out, vblank_out, hs_out, vs_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int r;
        int g;
        int b;
        int i;
        int er;
        int eg;
        int eb;
    } vec_t;

    vec_t vecs [7];

    bit hbPat [12] = '{0, 0, 1, 1, 1, 0, 0, 1, 0, 1, 0, 0};
    bit hsPat [12] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0};
    bit vsPat [12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0};
    bit vbPat [12] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};

    color_intensity_pipe dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .r_in        (r_in),
        .g_in        (g_in),
        .b_in        (b_in),
        .i_in        (i_in),
        .hblank_in   (hblank_in),
        .vblank_in   (vblank_in),
        .hs_in       (hs_in),
        .vs_in       (vs_in),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_pending (cfg_pending),
        .r_out       (r_out),
        .g_out       (g_out),
        .b_out       (b_out),
        .hblank_out  (hblank_out),
        .vblank_out  (vblank_out),
        .hs_out      (hs_out),
        .vs_out      (vs_out)
    );

    always #5 clk_sys = ~clk_sys;

    // Inputs change on the falling edge; outputs are sampled there too
    task automatic tick(input logic ce);
        ce_pix = ce;
        @(posedge clk_sys);
        @(negedge clk_sys);
        ce_pix = 1'b0;
    endtask

    task automatic ceStep(input int gap);
        repeat (gap) tick(1'b0);
        tick(1'b1);
    endtask

    task automatic applyStimulus(input vec_t v);
        r_in = 4'(v.r);
        g_in = 4'(v.g);
        b_in = 4'(v.b);
        i_in = 4'(v.i);
    endtask

    task automatic setPixel(input int r, input int g, input int b, input int i);
        r_in = 4'(r);
        g_in = 4'(g);
        b_in = 4'(b);
        i_in = 4'(i);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkColour(input string tag, input int er, input int eg, input int eb);
        checkOutput({tag, "_r"}, 32'(r_out), 32'(er));
        checkOutput({tag, "_g"}, 32'(g_out), 32'(eg));
        checkOutput({tag, "_b"}, 32'(b_out), 32'(eb));
    endtask

    // One-edge config write, optionally on a ce_pix edge
    task automatic cfgWrite(input logic [2:0] addr, input logic [7:0] data, input logic ce);
        cfg_addr = addr;
        cfg_data = data;
        cfg_we   = 1'b1;
        tick(ce);
        cfg_we   = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{15, 15, 15, 15,  8, 12, 10};
        vecs[1] = '{ 5,  5,  5, 15,  0,  4,  1};
        vecs[2] = '{15, 15, 15,  0,  0,  0,  0};
        vecs[3] = '{15, 15, 15,  8,  2,  6,  4};
        vecs[4] = '{10,  3,  7, 12,  2,  2,  2};
        vecs[5] = '{ 8,  8,  8, 10,  0,  4,  1};
        vecs[6] = '{ 9,  9,  9,  9,  0,  4,  2};

        reset     = 1'b1;
        ce_pix    = 1'b0;
        setPixel(0, 0, 0, 0);
        hblank_in = 1'b0;
        vblank_in = 1'b0;
        hs_in     = 1'b0;
        vs_in     = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;

        repeat (3) @(negedge clk_sys);
        checkColour("rst", 0, 0, 0);
        checkOutput("rst_hblank", 32'(hblank_out), 32'd1);
        checkOutput("rst_vblank", 32'(vblank_out), 32'd1);
        checkOutput("rst_hs", 32'(hs_out), 32'd0);
        checkOutput("rst_pending", 32'(cfg_pending), 32'd0);
        reset = 1'b0;
        tick(1'b0);
        checkOutput("post_rst_hblank", 32'(hblank_out), 32'd1);

        // Stream the table; output after step j belongs to vector j-2
        for (int j = 0; j < 9; j++) begin
            if (j < 7) applyStimulus(vecs[j]);
            ceStep((j % 2 == 0) ? 7 : 2);
            if (j >= 2) begin
                checkColour($sformatf("vec%0d", j - 2), vecs[j-2].er, vecs[j-2].eg, vecs[j-2].eb);
            end else begin
                checkOutput($sformatf("fill%0d_hblank", j), 32'(hblank_out), 32'd1);
            end
        end

        // Mid-frame config write stays shadowed until vblank_in rises
        setPixel(15, 15, 15, 15);
        repeat (3) ceStep(1);
        checkColour("pre_cfg", 8, 12, 10);
        cfgWrite(CFG_GAIN_R, 8'hFF, 1'b0);
        checkOutput("pend_same_edge", 32'(cfg_pending), 32'd0);
        cfgWrite(CFG_OFF_R, 8'h00, 1'b0);
        checkOutput("pend_next_cycle", 32'(cfg_pending), 32'd1);
        repeat (3) ceStep(1);
        checkColour("shadowed", 8, 12, 10);
        checkOutput("pend_held", 32'(cfg_pending), 32'd1);
        vblank_in = 1'b1;
        ceStep(2);
        checkOutput("pend_commit", 32'(cfg_pending), 32'd0);
        vblank_in = 1'b0;
        repeat (3) ceStep(1);
        checkColour("committed", 15, 12, 10);

        // Timing delay with irregular ce gaps; hold checked inside the gaps
        begin
            bit hbHist [$];
            bit hsHist [$];
            bit vsHist [$];
            bit vbHist [$];
            bit expHb, expHs, expVs, expVb;
            hbHist = '{0, 0};
            hsHist = '{0, 0};
            vsHist = '{0, 0};
            vbHist = '{0, 0};
            expHb = 1'b0;
            for (int k = 0; k < 12; k++) begin
                hblank_in = hbPat[k];
                hs_in     = hsPat[k];
                vs_in     = vsPat[k];
                vblank_in = vbPat[k];
                if (k % 3 != 0) begin
                    tick(1'b0);
                    checkOutput($sformatf("hold%0d_hblank", k), 32'(hblank_out), 32'(expHb));
                    repeat ((k % 3) - 1) tick(1'b0);
                end
                tick(1'b1);
                hbHist.push_back(hbPat[k]);
                hsHist.push_back(hsPat[k]);
                vsHist.push_back(vsPat[k]);
                vbHist.push_back(vbPat[k]);
                expHb = hbHist[hbHist.size() - 3];
                expHs = hsHist[hsHist.size() - 3];
                expVs = vsHist[vsHist.size() - 3];
                expVb = vbHist[vbHist.size() - 3];
                checkOutput($sformatf("tmg%0d_hblank", k), 32'(hblank_out), 32'(expHb));
                checkOutput($sformatf("tmg%0d_hs", k), 32'(hs_out), 32'(expHs));
                checkOutput($sformatf("tmg%0d_vs", k), 32'(vs_out), 32'(expVs));
                checkOutput($sformatf("tmg%0d_vblank", k), 32'(vblank_out), 32'(expVb));
                checkOutput($sformatf("tmg%0d_r", k), 32'(r_out), (expHb || expVb) ? 32'd0 : 32'd15);
            end
            hblank_in = 1'b0;
            hs_in     = 1'b0;
            vs_in     = 1'b0;
            vblank_in = 1'b0;
            repeat (3) ceStep(0);
            checkColour("tmg_flush", 15, 12, 10);
        end

        // Write on the commit edge: old shadow commits, new value stays pending
        vblank_in = 1'b1;
        cfgWrite(CFG_OFF_G, 8'h10, 1'b1);
        checkOutput("coll_pend_clr", 32'(cfg_pending), 32'd0);
        tick(1'b0);
        checkOutput("coll_pend_set", 32'(cfg_pending), 32'd1);
        vblank_in = 1'b0;
        repeat (3) ceStep(1);
        checkColour("coll_old", 15, 12, 10);
        vblank_in = 1'b1;
        ceStep(1);
        vblank_in = 1'b0;
        repeat (3) ceStep(1);
        checkColour("coll_new", 15, 11, 10);
        checkOutput("coll_pend_done", 32'(cfg_pending), 32'd0);

        // Addresses 6 and 7 are not registers
        cfgWrite(3'd6, 8'hFF, 1'b0);
        cfgWrite(3'd7, 8'h00, 1'b0);
        tick(1'b0);
        checkOutput("ign_pending", 32'(cfg_pending), 32'd0);
        vblank_in = 1'b1;
        ceStep(1);
        vblank_in = 1'b0;
        repeat (3) ceStep(1);
        checkColour("ign_colour", 15, 11, 10);

        // Reset with a pending write and a full pipe
        cfgWrite(CFG_GAIN_B, 8'h00, 1'b0);
        tick(1'b0);
        checkOutput("rst2_pend_before", 32'(cfg_pending), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkColour("rst2", 0, 0, 0);
        checkOutput("rst2_hblank", 32'(hblank_out), 32'd1);
        checkOutput("rst2_vblank", 32'(vblank_out), 32'd1);
        checkOutput("rst2_pending", 32'(cfg_pending), 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        setPixel(15, 15, 15, 15);
        repeat (3) ceStep(7);
        checkColour("rst2_defaults", 8, 12, 10);
        checkOutput("rst2_pend_after", 32'(cfg_pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_intensity_pipe.md
Name: color_intensity_pipe

Overview:
- Parametrised, pipelined successor to the inline colour/intensity palette math in the arcade top level.
- Per channel: multiplies RGB by the intensity nibble, subtracts a programmable black level, clamps at zero, applies a programmable gain and shift, then saturates to OUT_W bits.
- Sits between the williams2 video outputs and arcade_video.
- Delays blank/sync by the pipeline latency so video timing stays aligned; gain and offset values are double-buffered and swap in only at frame start.

Parameters:
- IN_W, 4, width of each r/g/b input.
- I_W, 4, width of the intensity input.
- G_W, 8, width of each gain value.
- SHIFT, 11, right shift applied after the gain multiply.
- OUT_W, 4, width of each output channel.
- OFF_R/OFF_G/OFF_B, 'h50/'h00/'h30, reset black-level offsets (P_W = IN_W+I_W bits).
- GAIN_R/GAIN_G/GAIN_B, 'h7D/'h72/'h7F, reset gains.

Ports:
- clk_sys  in  1  pixel-domain clock.
- reset  in  1  asynchronous, active-high.
- ce_pix  in  1  pipeline advance enable.
- r_in/g_in/b_in  in  IN_W  raw colour.
- i_in  in  I_W  intensity.
- hblank_in/vblank_in/hs_in/vs_in  in  1  timing in.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  3  0/1/2 = offset R/G/B; 3/4/5 = gain R/G/B; 6-7 ignored.
- cfg_data  in  max(P_W,G_W)  write value, truncated to field width.
- cfg_pending  out  1  shadow differs from active, awaiting frame start.
- r_out/g_out/b_out  out  OUT_W  corrected colour.
- hblank_out/vblank_out/hs_out/vs_out  out  1  timing delayed 3 ce_pix cycles.

Behaviour:
- Reset: all outputs 0; hblank_out/vblank_out 1; pipeline valid cleared. Shadow and active registers load the OFF_*/GAIN_* parameters; cfg_pending 0.
- Pipeline advances only on clk_sys edges with ce_pix=1; otherwise all stage registers hold.
- S1: p = c*i (P_W bits, unsigned).
- S2: d = (p > off) ? p-off : 0.
- S3: m = d*gain (P_W+G_W bits); q = m >> SHIFT; out = (q > 2^OUT_W-1) ? all-ones : q[OUT_W-1:0]. Saturation is mandatory; no wrap.
- Latency is exactly 3 ce_pix-qualified cycles for colour and timing alike.
- Timing bits pass through a 3-deep shift register gated by ce_pix.
- Blanking: when the S3-aligned hblank or vblank is 1, colour outputs are forced to 0.
- Config writes: cfg_we=1 writes the shadow register on the same edge, independent of ce_pix. cfg_pending is set the next cycle if any shadow differs from active.
- Commit: on a ce_pix cycle where vblank_in rises (0->1), all shadow values copy to active atomically and cfg_pending clears.
- A write in the same cycle as commit: the committed value is the pre-write shadow; the new write stays pending.
- Writes to cfg_addr 6/7 are ignored with no side effect.
- Reset asserted mid-frame: pipeline flushes immediately and shadow/active return to parameter defaults.
- Active values are used coherently across all three stages: S2 and S3 registers latch the offset/gain valid for the pixel being processed.

Optional Feature:
- Macro COLOR_DITHER_EN.
- Defined: a 2x2 ordered dither is added before the S3 shift. Add value = {0,2,3,1}[{line_odd,pix_odd}] << (SHIFT-2), so SHIFT must be ≥ 2. pix_odd toggles per ce_pix and clears on hblank_in; line_odd toggles on hs_in rising and clears on vblank_in. Saturation still applies after the add.
- Undefined: no dither logic and no parity counters; output is plain truncation.

Decomposition:
- Package color_pipe_pkg: cfg address constants (CFG_OFF_R..CFG_GAIN_B), derived width functions (P_W, M_W), default offset/gain localparams.
- One sub-module, color_channel_stage: the S1–S3 datapath for a single channel, instantiated three times.
- Timing delay line and config shadow/commit logic live in the top.

Test Plan:
- Defaults, r=g=b=15, i=15, blanks 0, ce_pix every 8 clocks -> after 3 ce cycles r=8, g=12, b=10.
- r=5, i=15 (p=75 < 'h50) -> r_out=0; g=5, i=15 -> g_out=(75*'h72)>>11=4.
- Write gain R='hFF, offset R=0 mid-frame -> cfg_pending=1 and output unchanged until the next vblank_in rise; then r=i=15 yields 28, saturated to r_out=15.
- Toggle hblank_in/hs_in with a ce_pix pattern containing gaps -> hblank_out/hs_out are exactly 3 ce_pix-qualified cycles late; colour is 0 while hblank_out=1.
- Assert reset while cfg_pending=1 and the pipeline is full -> all outputs 0, blanks 1, cfg_pending 0; a post-reset pixel 15/15/15 again gives 8/12/10.
- COLOR_DITHER_EN build: constant r=15, i=15 over a 2x2 pixel block -> outputs in {8,9}, with the pattern repeating on the 2x2 grid.
